// File: rtl/banner_scroller_pkg.sv
// Shared geometry constants, FSM state encoding and offset arithmetic for the banner scroller.
package banner_scroller_pkg;

    localparam int WORD_W = 71;
    localparam int ROWS   = 15;
    localparam int WIN_W  = 32;
    localparam int GAP    = 8;
    localparam int ADDR_W = 5;
    localparam int OFF_W  = 7;

    // One extra bit so offset + column index never overflows before wrapping.
    localparam logic [OFF_W:0] SPAN_X   = 8'(WORD_W + GAP);
    localparam logic [OFF_W:0] WORD_X   = 8'(WORD_W);
    localparam logic [3:0]     LAST_ROW = 4'(ROWS - 1);

    typedef logic [1:0] state_t;
    localparam state_t IDLE    = 2'd0;
    localparam state_t FETCH   = 2'd1;
    localparam state_t WAIT    = 2'd2;
    localparam state_t PRESENT = 2'd3;

    function automatic logic [OFF_W-1:0] offset_step(input logic [OFF_W-1:0] off);
        return (off == OFF_W'(WORD_W + GAP - 1)) ? '0 : off + OFF_W'(1);
    endfunction

endpackage

// File: rtl/banner_window_extract.sv
// Combinational window selector: picks WIN_W columns of the word-plus-gap ring starting at offset.
module banner_window_extract
    import banner_scroller_pkg::*;
(
    input  logic [WORD_W-1:0] rom_data,
    input  logic [OFF_W-1:0]  offset,
    output logic [WIN_W-1:0]  window
);

    generate
        for (genvar gi = 0; gi < WIN_W; gi++) begin : g_col
            logic [OFF_W:0]   pos_raw;
            logic [OFF_W:0]   pos;
            logic [OFF_W-1:0] bit_sel;

            assign pos_raw = {1'b0, offset} + (OFF_W+1)'(gi);
            // offset < SPAN and gi < WIN_W < SPAN, so a single subtraction completes the modulo.
            assign pos     = (pos_raw >= SPAN_X) ? pos_raw - SPAN_X : pos_raw;
            assign bit_sel = OFF_W'(WORD_X - 8'd1 - pos);
            assign window[WIN_W-1-gi] = (pos < WORD_X) ? rom_data[bit_sel] : 1'b0;
        end
    endgenerate

endmodule

// File: rtl/banner_scroller.sv
// Row-walking FSM: fetches each ROM row, windows it at the current offset and hands it to the row driver.
module banner_scroller
    import banner_scroller_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              scroll_tick,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [WORD_W-1:0] rom_data,
    output logic              row_valid,
    input  logic              row_ready,
    output logic [3:0]        row_idx,
    output logic [WIN_W-1:0]  row_pixels,
    output logic              frame_done,
    output logic [OFF_W-1:0]  offset
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        idx_q, idx_d;
    logic [WIN_W-1:0]  pix_q, pix_d;
    logic              fd_q, fd_d;
    logic [OFF_W-1:0]  off_q, off_d;
    logic              pend_q, pend_d;
    logic [WIN_W-1:0]  window;

    banner_window_extract u_extract (
        .rom_data (rom_data),
        .offset   (off_q),
        .window   (window)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        idx_d   = idx_q;
        pix_d   = pix_q;
        fd_d    = 1'b0;
        off_d   = off_q;
        pend_d  = pend_q | scroll_tick;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = FETCH;
                    addr_d  = ADDR_W'(idx_q);
                end
            end
            FETCH: state_d = WAIT;
            WAIT: begin
                pix_d   = window;
                state_d = PRESENT;
            end
            PRESENT: begin
                if (row_ready) begin
                    state_d = enable ? FETCH : IDLE;
                    if (idx_q == LAST_ROW) begin
                        idx_d  = '0;
                        addr_d = '0;
                        fd_d   = 1'b1;
                        if (pend_q) off_d = offset_step(off_q);
                        // A tick coinciding with the frame-end accept belongs to the next frame.
                        pend_d = scroll_tick;
                    end else begin
                        idx_d  = idx_q + 4'd1;
                        addr_d = addr_q + ADDR_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            idx_q   <= '0;
            pix_q   <= '0;
            fd_q    <= 1'b0;
            off_q   <= '0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            idx_q   <= idx_d;
            pix_q   <= pix_d;
            fd_q    <= fd_d;
            off_q   <= off_d;
            pend_q  <= pend_d;
        end
    end

    assign rom_addr   = addr_q;
    assign row_valid  = (state_q == PRESENT);
    assign row_idx    = idx_q;
    assign row_pixels = pix_q;
    assign frame_done = fd_q;
    assign offset     = off_q;

endmodule

// File: tb/tb_banner_scroller.sv
// Bench for banner_scroller: ROM model, cycle-level reference model with per-cycle compare, directed scenarios.
module tb_banner_scroller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        scroll_tick = 1'b0;
    logic [4:0]  rom_addr;
    logic [70:0] rom_data = '0;
    logic        row_valid;
    logic        row_ready = 1'b1;
    logic [3:0]  row_idx;
    logic [31:0] row_pixels;
    logic        frame_done;
    logic [6:0]  offset;

    int n_checks = 0;
    int n_err = 0;
    int fd_seen = 0;

    logic [70:0] rom_mem [0:14];

    banner_scroller dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .scroll_tick (scroll_tick),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .row_valid   (row_valid),
        .row_ready   (row_ready),
        .row_idx     (row_idx),
        .row_pixels  (row_pixels),
        .frame_done  (frame_done),
        .offset      (offset)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= (rom_addr < 5'd15) ? rom_mem[rom_addr] : '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Window straight from the column rule: ring of WORD_W columns followed by GAP blanks.
    function automatic logic [31:0] win(input logic [70:0] w, input int off);
        logic [31:0] r;
        for (int c = 0; c < 32; c++) begin
            int p;
            p = (off + c) % 79;
            r[31-c] = (p < 71) ? w[70-p] : 1'b0;
        end
        return r;
    endfunction

    // Reference model, advanced on the same edge the DUT samples its inputs.
    int  m_row = 0, m_off = 0, m_age = 0;
    bit  m_busy = 0, m_pend = 0, m_fd = 0, m_live = 0;
    wire m_valid = m_busy && (m_age == 2);

    always @(posedge clk) begin
        bit acc, fe;
        if (!rst_n) begin
            m_row = 0; m_off = 0; m_age = 0;
            m_busy = 0; m_pend = 0; m_fd = 0;
        end else begin
            acc  = m_valid && row_ready;
            fe   = acc && (m_row == 14);
            m_fd = fe;
            if (fe && m_pend) m_off = (m_off + 1) % 79;
            m_pend = scroll_tick || (m_pend && !fe);
            if (acc) begin
                m_row  = fe ? 0 : m_row + 1;
                m_busy = enable;
                m_age  = 0;
            end else if (m_busy) begin
                if (m_age < 2) m_age++;
            end else if (enable) begin
                m_busy = 1;
                m_age  = 0;
            end
        end
        m_live = 1;
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("row_valid", 64'(row_valid), 64'(m_valid));
            chk("row_idx", 64'(row_idx), 64'(m_row));
            chk("offset", 64'(offset), 64'(m_off));
            chk("frame_done", 64'(frame_done), 64'(m_fd));
            if (m_valid) begin
                chk("row_pixels", 64'(row_pixels), 64'(win(rom_mem[m_row], m_off)));
                chk("rom_addr", 64'(rom_addr), 64'(m_row));
            end
            if (frame_done) fd_seen++;
            if (row_valid && row_ready)
                $display("row %0d accepted px=%08h offset=%0d t=%0t", row_idx, row_pixels, offset, $time);
        end
    end

    task automatic wait_row(input int r);
        bit hit = 0;
        for (int k = 0; k < 400 && !hit; k++) begin
            @(negedge clk);
            if (row_valid && row_idx == 4'(r)) hit = 1;
        end
        chk($sformatf("wait_row%0d", r), 64'(hit), 64'd1);
    endtask

    task automatic wait_frame();
        bit hit = 0;
        for (int k = 0; k < 400 && !hit; k++) begin
            @(negedge clk);
            if (frame_done) hit = 1;
        end
        chk("wait_frame", 64'(hit), 64'd1);
    endtask

    task automatic tick_then_frame();
        @(posedge clk); #1 scroll_tick = 1'b1;
        @(posedge clk); #1 scroll_tick = 1'b0;
        wait_frame();
    endtask

    initial begin
        int lat;
        int fd0;
        logic [4:0] addr_hold;
        for (int r = 0; r < 15; r++) begin
            logic [95:0] t;
            t = {$urandom, $urandom, $urandom};
            rom_mem[r] = t[70:0];
        end
        rom_mem[0] = {32'h00007E3F, 28'h0, 11'b00111111111};
        rom_mem[3] = {32'hC0038007, 39'h55_AAAA_F0F0};

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 64'(row_valid), 64'd0);
        chk("rst_pixels", 64'(row_pixels), 64'd0);
        chk("rst_addr", 64'(rom_addr), 64'd0);
        chk("rst_offset", 64'(offset), 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Three edges from enable to PRESENT: valid seen on the 4th negedge after the drive.
        @(posedge clk); #1 enable = 1'b1;
        lat = 0;
        for (int k = 0; k < 20 && !row_valid; k++) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", 64'(lat), 64'd4);
        chk("row0_idx", 64'(row_idx), 64'd0);
        chk("row0_px", 64'(row_pixels), 64'h00007E3F);

        wait_row(3);
        chk("row3_px", 64'(row_pixels), 64'hC0038007);
        fd0 = fd_seen;
        wait_frame();
        repeat (5) @(negedge clk);
        chk("fd_once", 64'(fd_seen - fd0), 64'd1);

        // Sixty frames with one tick each
        for (int f = 0; f < 60; f++) tick_then_frame();
        chk("offset60", 64'(offset), 64'd60);
        wait_row(0);
        chk("off60_row0_px", 64'(row_pixels), 64'h3FE00000);

        for (int f = 0; f < 18; f++) tick_then_frame();
        chk("offset78", 64'(offset), 64'd78);
        tick_then_frame();
        chk("offset_wrap", 64'(offset), 64'd0);

        // Three ticks in one frame collapse to one step
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1 scroll_tick = 1'b1;
            @(posedge clk); #1 scroll_tick = 1'b0;
            repeat (3) @(posedge clk);
        end
        wait_frame();
        chk("three_ticks", 64'(offset), 64'd1);

        // Tick in the frame-end accept cycle is deferred one frame
        wait_row(14);
        #1 scroll_tick = 1'b1;
        @(posedge clk); #1 scroll_tick = 1'b0;
        wait_frame();
        chk("tick_at_end_kept", 64'(offset), 64'd1);
        wait_frame();
        chk("tick_at_end_applied", 64'(offset), 64'd2);

        // Back-pressure: ten cycles with row_ready low
        @(posedge clk); #1 row_ready = 1'b0;
        wait_row(m_row);
        addr_hold = 5'(m_row);
        fd0 = fd_seen;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("stall_valid", 64'(row_valid), 64'd1);
            chk("stall_px", 64'(row_pixels), 64'(win(rom_mem[addr_hold], 2)));
            chk("stall_addr", 64'(rom_addr), 64'(addr_hold));
        end
        chk("stall_no_fd", 64'(fd_seen - fd0), 64'd0);
        #1 row_ready = 1'b1;

        // enable low mid-frame: row 5 completes, then idle at row 6
        wait_row(5);
        #1 enable = 1'b0;
        repeat (8) @(negedge clk);
        chk("idle_valid", 64'(row_valid), 64'd0);
        chk("idle_idx", 64'(row_idx), 64'd6);
        #1 enable = 1'b1;

        // Reset in PRESENT at row 7
        wait_row(7);
        fd0 = fd_seen;
        #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_valid", 64'(row_valid), 64'd0);
        chk("mid_rst_idx", 64'(row_idx), 64'd0);
        chk("mid_rst_px", 64'(row_pixels), 64'd0);
        chk("mid_rst_offset", 64'(offset), 64'd0);
        chk("mid_rst_fd", 64'(frame_done), 64'd0);
        wait_row(0);
        chk("post_rst_px", 64'(row_pixels), 64'h00007E3F);
        chk("post_rst_no_fd", 64'(fd_seen - fd0), 64'd0);

        repeat (4) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
